// File: rtl/dma_channel_program_regs_if.sv
// CPU I/O programming bus for the DMA channel base registers (8237-style strobes).
interface dma_channel_program_regs_if;
    logic       CS_n;
    logic       IOW_n;
    logic       IOR_n;
    logic [3:0] A;
    logic [7:0] db_in;
    logic [7:0] db_out;
    logic       db_oe;

    modport master (
        output CS_n, IOW_n, IOR_n, A, db_in,
        input  db_out, db_oe
    );

    modport slave (
        input  CS_n, IOW_n, IOR_n, A, db_in,
        output db_out, db_oe
    );
endinterface

// File: rtl/dma_channel_program_regs.sv
// CPU-side base address / word count programming for a 4-channel DMA with byte-pointer flip-flop.
// Optional readback path enabled by defining DMA_PROG_READBACK_EN.
module dma_channel_program_regs #(
    parameter int unsigned NUM_CH   = 4,
    parameter logic [15:0] RST_ADDR = 16'h0000,
    parameter logic [15:0] RST_WORD = 16'h0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dma_channel_program_regs_if.slave   io_cpu,
    input  logic [1:0]                  ch_select,
    input  logic [15:0]                 cur_address,
    input  logic [15:0]                 cur_word,
    output logic [15:0]                 base_address,
    output logic [15:0]                 base_word,
    output logic                        load_strobe,
    output logic [1:0]                  load_ch
);

    localparam int unsigned CH_W = 2;

    logic [15:0]     r_base_addr [NUM_CH];
    logic [15:0]     r_base_word [NUM_CH];
    logic            r_ff;
    logic            r_iow_q;
    logic            r_ior_q;
    logic            r_load_pend;
    logic [CH_W-1:0] r_load_ch_pend;

    logic            w_wr;
    logic            w_rd_toggle;
    logic [CH_W-1:0] w_ch;

    assign w_ch = io_cpu.A[2:1];

    // Falling-edge detect; simultaneous read and write strobes cancel each other.
    assign w_wr = !io_cpu.CS_n && !io_cpu.IOW_n && r_iow_q && io_cpu.IOR_n;

    assign base_address = r_base_addr[ch_select];
    assign base_word    = r_base_word[ch_select];

`ifdef DMA_PROG_READBACK_EN
    logic       w_rd;
    logic [15:0] w_rd_word;
    logic [7:0]  w_rd_byte;
    logic [7:0]  r_db_out;
    logic        r_db_oe;

    assign w_rd        = !io_cpu.CS_n && !io_cpu.IOR_n && r_ior_q && io_cpu.IOW_n;
    assign w_rd_toggle = w_rd && !io_cpu.A[3];

    // Live buffer counters only belong to the serviced channel; others read back their base.
    always_comb begin
        w_rd_word = 16'h0000;
        w_rd_byte = 8'h00;
        if (w_ch == ch_select) begin
            w_rd_word = io_cpu.A[0] ? cur_word : cur_address;
        end else begin
            w_rd_word = io_cpu.A[0] ? r_base_word[w_ch] : r_base_addr[w_ch];
        end
        if (!io_cpu.A[3]) begin
            w_rd_byte = r_ff ? w_rd_word[15:8] : w_rd_word[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_out <= 8'h00;
            r_db_oe  <= 1'b0;
        end else begin
            if (w_rd) begin
                r_db_out <= w_rd_byte;
            end
            r_db_oe <= w_rd || (r_db_oe && !io_cpu.CS_n && !io_cpu.IOR_n);
        end
    end

    assign io_cpu.db_out = r_db_out;
    assign io_cpu.db_oe  = r_db_oe;
`else
    logic w_unused_readback;

    assign w_rd_toggle       = 1'b0;
    assign w_unused_readback = ^{cur_address, cur_word};
    assign io_cpu.db_out     = 8'h00;
    assign io_cpu.db_oe      = 1'b0;
`endif

    // Register file, byte pointer and load strobe pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_base_addr[CH_W'(i)] <= RST_ADDR;
                r_base_word[CH_W'(i)] <= RST_WORD;
            end
            r_ff           <= 1'b0;
            r_iow_q        <= 1'b1;
            r_ior_q        <= 1'b1;
            r_load_pend    <= 1'b0;
            r_load_ch_pend <= '0;
            load_strobe    <= 1'b0;
            load_ch        <= '0;
        end else begin
            r_iow_q     <= io_cpu.IOW_n;
            r_ior_q     <= io_cpu.IOR_n;
            r_load_pend <= 1'b0;
            load_strobe <= r_load_pend;
            if (r_load_pend) begin
                load_ch <= r_load_ch_pend;
            end
            if (w_wr) begin
                if (!io_cpu.A[3]) begin
                    case ({io_cpu.A[0], r_ff})
                        2'b00: r_base_addr[w_ch][7:0]  <= io_cpu.db_in;
                        2'b01: r_base_addr[w_ch][15:8] <= io_cpu.db_in;
                        2'b10: r_base_word[w_ch][7:0]  <= io_cpu.db_in;
                        default: begin
                            r_base_word[w_ch][15:8] <= io_cpu.db_in;
                            r_load_pend             <= 1'b1;
                            r_load_ch_pend          <= w_ch;
                        end
                    endcase
                    r_ff <= ~r_ff;
                end else if (io_cpu.A == 4'hC) begin
                    r_ff <= 1'b0;
                end else if (io_cpu.A == 4'hD) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        r_base_addr[CH_W'(i)] <= RST_ADDR;
                        r_base_word[CH_W'(i)] <= RST_WORD;
                    end
                    r_ff <= 1'b0;
                end
            end else if (w_rd_toggle) begin
                r_ff <= ~r_ff;
            end
        end
    end

endmodule

// File: tb/tb_dma_channel_program_regs.sv
// Scoreboard bench for dma_channel_program_regs: load strobes and readback bytes are checked by monitors.
module tb_dma_channel_program_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ch_select;
    logic [15:0] cur_address;
    logic [15:0] cur_word;
    logic [15:0] base_address;
    logic [15:0] base_word;
    logic        load_strobe;
    logic [1:0]  load_ch;

    always #5 clk = ~clk;

    dma_channel_program_regs_if cpu ();

    dma_channel_program_regs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_cpu       (cpu),
        .ch_select    (ch_select),
        .cur_address  (cur_address),
        .cur_word     (cur_word),
        .base_address (base_address),
        .base_word    (base_word),
        .load_strobe  (load_strobe),
        .load_ch      (load_ch)
    );

    typedef struct {
        logic [1:0] ch;
        int         cyc;
    } load_exp_t;

    load_exp_t  q_load [$];
    logic [7:0] q_rd   [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    bit         prev_oe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Load-strobe monitor: every strobe cycle must match a queued expectation.
    always @(negedge clk) begin
        if (load_strobe) begin
            if (q_load.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL load_strobe_unexpected: got load_ch=%0d at cycle %0d expected no strobe", load_ch, cyc);
            end else begin
                load_exp_t e;
                e = q_load.pop_front();
                chk("load_ch", 16'(load_ch), 16'(e.ch));
                chk("load_cycle", 16'(cyc), 16'(e.cyc));
            end
        end
    end

    // Readback monitor: compare db_out when db_oe first rises.
    always @(negedge clk) begin
        if (cpu.db_oe && !prev_oe) begin
            if (q_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL db_oe_unexpected: got db_out=%h expected no read", cpu.db_out);
            end else begin
                chk("db_out", 16'(cpu.db_out), 16'(q_rd.pop_front()));
            end
        end
        prev_oe = cpu.db_oe;
    end

    task automatic io_write(input logic [3:0] a, input logic [7:0] d,
                            input int hold = 1, input bit strobe = 1'b0, input logic [1:0] ch = 2'd0);
        load_exp_t e;
        @(posedge clk);
        #2;
        cpu.CS_n  = 1'b0;
        cpu.A     = a;
        cpu.db_in = d;
        cpu.IOW_n = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (i == 0 && strobe) begin
                e.ch  = ch;
                e.cyc = cyc + 1;
                q_load.push_back(e);
            end
        end
        #1;
        cpu.IOW_n = 1'b1;
        cpu.CS_n  = 1'b1;
    endtask

    task automatic io_read(input logic [3:0] a, input logic [7:0] exp, input int hold = 1);
        @(posedge clk);
        #2;
        cpu.CS_n  = 1'b0;
        cpu.A     = a;
        cpu.IOR_n = 1'b0;
`ifdef DMA_PROG_READBACK_EN
        q_rd.push_back(exp);
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
`ifdef DMA_PROG_READBACK_EN
            chk("db_oe_hold", 16'(cpu.db_oe), 16'h1);
`else
            chk("db_oe_off", 16'(cpu.db_oe), 16'h0);
            chk("db_out_off", 16'(cpu.db_out), 16'(exp));
`endif
        end
        cpu.IOR_n = 1'b1;
        cpu.CS_n  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("db_oe_drop", 16'(cpu.db_oe), 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        cpu.CS_n    = 1'b1;
        cpu.IOW_n   = 1'b1;
        cpu.IOR_n   = 1'b1;
        cpu.A       = 4'h0;
        cpu.db_in   = 8'h00;
        ch_select   = 2'd0;
        cur_address = 16'h0000;
        cur_word    = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_base_address", base_address, 16'h0000);
        chk("rst_base_word", base_word, 16'h0000);
        chk("rst_load_strobe", 16'(load_strobe), 16'h0);
        chk("rst_db_out", 16'(cpu.db_out), 16'h0);
        chk("rst_db_oe", 16'(cpu.db_oe), 16'h0);
        rst_n = 1'b1;

        // ch1 address, no strobe expected
        ch_select = 2'd1;
        io_write(4'h2, 8'h34);
        io_write(4'h2, 8'h12);
        @(negedge clk);
        chk("ch1_addr", base_address, 16'h1234);
        chk("ch1_word", base_word, 16'h0000);

        // ch3 word count, strobe for ch3
        io_write(4'h7, 8'h10);
        io_write(4'h7, 8'h00, 1, 1'b1, 2'd3);
        ch_select = 2'd3;
        @(negedge clk);
        chk("ch3_word", base_word, 16'h0010);
        chk("ch3_addr", base_address, 16'h0000);

        // clear byte pointer between low bytes
        io_write(4'h0, 8'hAA);
        io_write(4'hC, 8'h00);
        io_write(4'h0, 8'h55);
        io_write(4'h0, 8'h66);
        ch_select = 2'd0;
        @(negedge clk);
        chk("ch0_addr_after_clr", base_address, 16'h6655);

        // long strobe is a single event
        io_write(4'h4, 8'h78, 5);
        io_write(4'h4, 8'h9A);
        ch_select = 2'd2;
        @(negedge clk);
        chk("ch2_addr_long_strobe", base_address, 16'h9A78);

        // both strobes low together: ignored, pointer held
        @(posedge clk);
        #2;
        cpu.CS_n  = 1'b0;
        cpu.A     = 4'h4;
        cpu.db_in = 8'h11;
        cpu.IOW_n = 1'b0;
        cpu.IOR_n = 1'b0;
        @(posedge clk);
        #2;
        cpu.IOW_n = 1'b1;
        cpu.IOR_n = 1'b1;
        cpu.CS_n  = 1'b1;
        @(negedge clk);
        chk("both_low_ignored", base_address, 16'h9A78);
        io_write(4'h4, 8'h22);
        @(negedge clk);
        chk("ff_held_both_low", base_address, 16'h9A22);
        io_write(4'hC, 8'h00);

        // program ch2 word, then master clear after a lone low byte
        io_write(4'h5, 8'h01);
        io_write(4'h5, 8'h02, 1, 1'b1, 2'd2);
        @(negedge clk);
        chk("ch2_word", base_word, 16'h0201);
        io_write(4'h4, 8'h5C);
        io_write(4'hD, 8'h00);
        @(negedge clk);
        chk("mclr_ch2_addr", base_address, 16'h0000);
        chk("mclr_ch2_word", base_word, 16'h0000);
        io_write(4'h4, 8'h01);
        @(negedge clk);
        chk("mclr_ff_zero", base_address, 16'h0001);
        ch_select = 2'd1;
        @(negedge clk);
        chk("mclr_ch1_addr", base_address, 16'h0000);
        io_write(4'hC, 8'h00);

        // reset after a lone low byte
        io_write(4'h2, 8'h33);
        #3;
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        io_write(4'h2, 8'h44);
        @(negedge clk);
        chk("rst_mid_ff_zero", base_address, 16'h0044);

        // readback
        ch_select   = 2'd0;
        cur_address = 16'hBEEF;
        cur_word    = 16'hCAFE;
        io_write(4'hC, 8'h00);
`ifdef DMA_PROG_READBACK_EN
        io_read(4'h0, 8'hEF, 3);
        io_read(4'h0, 8'hBE);
        io_read(4'h1, 8'hFE);
        io_read(4'h1, 8'hCA);
        io_read(4'h2, 8'h44);
        io_read(4'h2, 8'h00);
        io_read(4'hC, 8'h00);
`else
        io_read(4'h0, 8'h00, 3);
`endif
        io_write(4'h0, 8'h12);
        io_write(4'h0, 8'h34);
        @(negedge clk);
        chk("ff_after_reads", base_address, 16'h3412);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("load_queue_empty", 16'(q_load.size()), 16'h0);
        chk("read_queue_empty", 16'(q_rd.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_channel_program_regs.md
Name: dma_channel_program_regs

Overview:
- CPU-side programming port for the 4-channel DMA controller; the writer that fills the per-channel base address and base word count consumed by the read/write buffer.
- Accepts 8-bit I/O writes/reads through an 8237-style byte-pointer flip-flop, holds base registers for all 4 channels, and presents the selected channel's values.
- Issues a one-cycle load strobe so the buffer can copy base into current once a channel is fully programmed.

Parameters:
- NUM_CH, 4, number of channels; fixed at 4 and sets the width of ch_select and load_ch (2 bits).
- RST_ADDR, 16'h0000, reset and master-clear value of every base address register.
- RST_WORD, 16'h0000, reset and master-clear value of every base word register.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- CS_n  input  1  chip select, active low; sampled on clk.
- IOW_n  input  1  CPU I/O write strobe, active low; sampled on clk.
- IOR_n  input  1  CPU I/O read strobe, active low; sampled on clk.
- A  input  4  register address.
- db_in  input  8  CPU write data.
- db_out  output  8  CPU read data, registered.
- db_oe  output  1  read-data drive enable.
- ch_select  input  2  channel currently serviced by the buffer.
- cur_address  input  16  current address of ch_select from the buffer, used for readback.
- cur_word  input  16  current word count of ch_select from the buffer, used for readback.
- base_address  output  16  base address of channel ch_select (combinational mux).
- base_word  output  16  base word count of channel ch_select (combinational mux).
- load_strobe  output  1  one-cycle pulse: a channel's word-count high byte was written.
- load_ch  output  2  channel index qualifying load_strobe.

Behaviour:
- Reset (rst_n=0, async): all base_address regs = RST_ADDR; all base_word regs = RST_WORD; byte pointer ff=0; db_out=0; db_oe=0; load_strobe=0; load_ch=0; strobe history regs iow_q=1 and ior_q=1.
- Edge detect: write event = CS_n==0 && IOW_n==0 && iow_q==1. Read event is the same using IOR_n/ior_q. Exactly one action per strobe regardless of how many cycles the strobe stays low.
- If IOW_n and IOR_n are both low in the same cycle, neither event fires, no state changes, and ff is held. Strobe history regs still update.
- Address map, channel n = A[2:1]:
  - A3=0, A0=0: base address of channel n.
  - A3=0, A0=1: base word count of channel n.
  - A=4'hC: clear byte pointer (ff=0).
  - A=4'hD: master clear (all regs to reset values, ff=0).
  - Other A3=1 codes: ignored, ff unchanged.
- Write to a channel register: ff=0 writes bits [7:0], ff=1 writes bits [15:8]. The register updates on the same edge the event is detected, and ff toggles.
- load_strobe: asserted for exactly one cycle on the edge after a word-count write with ff=1, with load_ch=n. Address writes never strobe. Master clear does not strobe.
- Read of a channel register returns the low byte of cur_address/cur_word when ff=0 and the high byte when ff=1. db_out is registered on the read event, and ff toggles.
- Readback is valid only when A[2:1]==ch_select. Otherwise db_out = base register byte of channel A[2:1].
- Read of 4'hC, 4'hD, or reserved codes: db_out=8'h00, ff unchanged.
- db_oe = 1 from the cycle after the read event while CS_n==0 && IOR_n==0; it drops to 0 the cycle after either goes high.
- base_address/base_word follow ch_select combinationally. A write to the selected channel is visible the cycle after the write edge.
- ff is a single pointer shared by all channels and both register kinds.
- Reset mid-sequence (after a low byte only): ff returns to 0. The next write is treated as a low byte.

Optional Feature:
- DMA_PROG_READBACK_EN:
  - Defined: read path as described.
  - Undefined: db_out tied 8'h00, db_oe tied 0, read events do not toggle ff, and cur_address/cur_word are unused.

Test Plan:
- Reset then write 8'h34, 8'h12 to A=4'h2 (ch1 addr), ch_select=1 -> base_address=16'h1234, ff back to 0, load_strobe never asserted.
- Write 8'h10, 8'h00 to A=4'h7 (ch3 word) -> base_word[3]=16'h0010. load_strobe high exactly one cycle with load_ch=3, one cycle after the second write edge.
- Write 8'hAA to A=4'h0, then write A=4'hC, then write 8'h55, 8'h66 to A=4'h0 -> ch0 base_address=16'h6655.
- Hold IOW_n low for 5 cycles on a single low-byte write -> only the low byte is written, ff=1 (no double toggle).
- Program ch2, write A=4'hD -> all base regs 0, ff=0, no load_strobe. Assert rst_n low after a single low byte -> ff=0.
- With DMA_PROG_READBACK_EN, ch_select=0, cur_address=16'hBEEF, two reads of A=4'h0 -> db_out 8'hEF then 8'hBE, db_oe follows IOR_n. Without the macro -> db_out=0, db_oe=0.
